// File: rtl/ysyx_22040237_lsu_pkg.sv
`default_nettype none
// ==================================================================
// Package : ysyx_22040237_lsu_pkg
// LS-info bit positions, access-size codes and LSU state encoding.
// Rev     : 1.0
// ==================================================================
package ysyx_22040237_lsu_pkg;

   localparam int LS_LOAD  = 0;
   localparam int LS_STORE = 1;
   localparam int LS_USIGN = 2;
   localparam int LS_BYTE  = 3;
   localparam int LS_DB    = 4;
   localparam int LS_WORD  = 5;
   localparam int LS_DW    = 6;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   function automatic logic [1:0] ls_size(input logic [6:0] info);
      if (info[LS_DW])        return SZ_D;
      else if (info[LS_WORD]) return SZ_W;
      else if (info[LS_DB])   return SZ_H;
      else                    return SZ_B;
   endfunction

   // Exactly one of the four size bits must be set.
   function automatic logic ls_size_ok(input logic [6:0] info);
      return (info[6:3] == 4'b0001) || (info[6:3] == 4'b0010) ||
             (info[6:3] == 4'b0100) || (info[6:3] == 4'b1000);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040237_lsu_lane.sv
`default_nettype none
// ==================================================================
// Module : ysyx_22040237_lsu_lane
// Byte-lane steering: store shift/strobes, load extract/extend, misalign.
// Rev    : 1.0
// ==================================================================
module ysyx_22040237_lsu_lane
   import ysyx_22040237_lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      a,
   input  logic [1:0]      size,
   input  logic            usign,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] wdata,
   output logic [7:0]      wstrb,
   output logic [XLEN-1:0] ldata,
   output logic            misalign
);

   logic [XLEN-1:0] w_sh;
   logic [5:0]      w_bit_off;

   assign w_bit_off = {a, 3'b000};
   assign w_sh      = rdata >> w_bit_off;
   assign wdata     = rs2 << w_bit_off;

   always_comb begin
      wstrb    = 8'h00;
      ldata    = '0;
      misalign = 1'b0;
      case (size)
         SZ_B: begin
            wstrb = 8'h01 << a;
            ldata = {{(XLEN-8){w_sh[7] & ~usign}}, w_sh[7:0]};
         end
         SZ_H: begin
            wstrb    = 8'h03 << a;
            ldata    = {{(XLEN-16){w_sh[15] & ~usign}}, w_sh[15:0]};
            misalign = a[0];
         end
         SZ_W: begin
            wstrb    = 8'h0F << a;
            ldata    = {{(XLEN-32){w_sh[31] & ~usign}}, w_sh[31:0]};
            misalign = (a[1:0] != 2'b00);
         end
         default: begin
            wstrb    = 8'hFF;
            ldata    = w_sh;
            misalign = (a != 3'b000);
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040237_lsu.sv
`default_nettype none
// ==================================================================
// Module : ysyx_22040237_lsu
// Memory-access stage: one bus transaction per load/store, registered writeback.
// Rev    : 1.0
// ==================================================================
module ysyx_22040237_lsu
   import ysyx_22040237_lsu_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int XLEN   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  logic              rd_wr_en_i,
   input  logic [4:0]        rd_idx_i,
   input  logic [ADDR_W-1:0] alu_res_i,
   input  logic [6:0]        ls_info_bus_i,
   input  logic [XLEN-1:0]   rs2_store_i,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic [ADDR_W-1:0] mem_req_addr_o,
   output logic              mem_req_wen_o,
   output logic [XLEN-1:0]   mem_req_wdata_o,
   output logic [7:0]        mem_req_wstrb_o,
   input  logic              mem_rsp_valid_i,
   input  logic [XLEN-1:0]   mem_rsp_rdata_i,
   output logic              wb_valid_o,
   output logic              wb_rd_wr_en_o,
   output logic [4:0]        wb_rd_idx_o,
   output logic [XLEN-1:0]   wb_data_o,
   output logic              fault_o
);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic              r_usign;
   logic              r_store;
   logic              r_rd_wen;
   logic [4:0]        r_rd_idx;
   logic [XLEN-1:0]   r_rs2;
   logic              r_wb_valid;
   logic              r_wb_wen;
   logic [4:0]        r_wb_idx;
   logic [XLEN-1:0]   r_wb_data;
   logic              r_fault;

   logic              w_idle;
   logic              w_req;
   logic              w_is_ld;
   logic              w_is_st;
   logic              w_illegal;
   logic [2:0]        w_lane_a;
   logic [1:0]        w_lane_size;
   logic [XLEN-1:0]   w_wdata;
   logic [7:0]        w_wstrb;
   logic [XLEN-1:0]   w_ldata;
   logic              w_misalign;

   assign w_idle  = (r_state == ST_IDLE);
   assign w_req   = (r_state == ST_REQ);
   assign w_is_ld = ls_info_bus_i[LS_LOAD];
   assign w_is_st = ls_info_bus_i[LS_STORE];

   // In IDLE the lane unit checks the incoming access; afterwards it works on the latched one.
   assign w_lane_a    = w_idle ? alu_res_i[2:0] : r_addr[2:0];
   assign w_lane_size = w_idle ? ls_size(ls_info_bus_i) : r_size;
   assign w_illegal   = (w_is_ld & w_is_st) | ~ls_size_ok(ls_info_bus_i) | w_misalign;

   ysyx_22040237_lsu_lane #(.XLEN(XLEN)) u_lane (
      .a        (w_lane_a),
      .size     (w_lane_size),
      .usign    (r_usign),
      .rs2      (r_rs2),
      .rdata    (mem_rsp_rdata_i),
      .wdata    (w_wdata),
      .wstrb    (w_wstrb),
      .ldata    (w_ldata),
      .misalign (w_misalign)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_size     <= SZ_B;
         r_usign    <= 1'b0;
         r_store    <= 1'b0;
         r_rd_wen   <= 1'b0;
         r_rd_idx   <= '0;
         r_rs2      <= '0;
         r_wb_valid <= 1'b0;
         r_wb_wen   <= 1'b0;
         r_wb_idx   <= '0;
         r_wb_data  <= '0;
         r_fault    <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (ex_valid_i) begin
                  if (!w_is_ld && !w_is_st) begin
                     r_wb_valid <= 1'b1;
                     r_wb_wen   <= rd_wr_en_i;
                     r_wb_idx   <= rd_idx_i;
                     r_wb_data  <= XLEN'(alu_res_i);
                     r_fault    <= 1'b0;
                  end else if (w_illegal) begin
                     r_wb_valid <= 1'b1;
                     r_wb_wen   <= 1'b0;
                     r_wb_idx   <= rd_idx_i;
                     r_wb_data  <= '0;
                     r_fault    <= 1'b1;
                  end else begin
                     r_addr   <= alu_res_i;
                     r_size   <= ls_size(ls_info_bus_i);
                     r_usign  <= ls_info_bus_i[LS_USIGN];
                     r_store  <= w_is_st;
                     r_rd_wen <= rd_wr_en_i;
                     r_rd_idx <= rd_idx_i;
                     r_rs2    <= rs2_store_i;
                     r_state  <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (mem_req_ready_i) r_state <= ST_RESP;
            end
            ST_RESP: begin
               if (mem_rsp_valid_i) begin
                  r_wb_valid <= 1'b1;
                  r_wb_wen   <= r_store ? 1'b0 : r_rd_wen;
                  r_wb_idx   <= r_rd_idx;
                  r_wb_data  <= r_store ? '0 : w_ldata;
                  r_fault    <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ex_ready_o      = w_idle;
   assign mem_req_valid_o = w_req;
   assign mem_req_addr_o  = w_req ? {r_addr[ADDR_W-1:3], 3'b000} : '0;
   assign mem_req_wen_o   = w_req & r_store;
   assign mem_req_wdata_o = w_req ? w_wdata : '0;
   assign mem_req_wstrb_o = (w_req && r_store) ? w_wstrb : 8'h00;

   assign wb_valid_o    = r_wb_valid;
   assign wb_rd_wr_en_o = r_wb_wen;
   assign wb_rd_idx_o   = r_wb_idx;
   assign wb_data_o     = r_wb_data;
   assign fault_o       = r_fault;

endmodule
`default_nettype wire

// File: doc/ysyx_22040237_lsu.md
Name: ysyx_22040237_lsu

Overview:
- Memory-access stage on the consumer side of the execute unit's load/store interface.
- Accepts the execute result: rd info, address or ALU result, `ls_info_bus`, and store data.
- Runs one valid/ready request/response transaction on the data-memory bus per load or store. Handles byte-lane alignment, write strobes and load sign/zero extension, then delivers a registered writeback.
- Non-memory instructions pass straight through with one cycle of latency.

Parameters:
- ADDR_W, 64, width of address and `alu_res_i`.
- XLEN, 64, width of data path; `rs2_store_i`, `wb_data_o` and the memory data buses are this width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid_i  in  1  execute-stage instruction valid
- ex_ready_o  out  1  LSU can accept an instruction this cycle
- rd_wr_en_i  in  1  rd write enable from execute
- rd_idx_i  in  5  rd index
- alu_res_i  in  ADDR_W  ALU result; effective address for load/store
- ls_info_bus_i  in  7  {dw, word, db(half), byte, usign, store, load}, load at bit 0
- rs2_store_i  in  XLEN  store data (unshifted)
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  ADDR_W  8-byte-aligned address (addr[2:0]=0)
- mem_req_wen_o  out  1  1=store, 0=load
- mem_req_wdata_o  out  XLEN  lane-shifted store data
- mem_req_wstrb_o  out  8  byte write strobes; 0 for loads
- mem_rsp_valid_i  in  1  response valid (always accepted)
- mem_rsp_rdata_i  in  XLEN  aligned 64-bit read data
- wb_valid_o  out  1  writeback valid, one-cycle pulse
- wb_rd_wr_en_o  out  1  rd write enable
- wb_rd_idx_o  out  5  rd index
- wb_data_o  out  XLEN  writeback data
- fault_o  out  1  misaligned/illegal LS encoding, qualified by wb_valid_o

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE.
  - All outputs go to 0 except ex_ready_o, which is 1.
  - Reset mid-transaction aborts it. A response arriving afterwards is ignored because mem_rsp_valid_i is sampled only in RESP.
- FSM states:
  - IDLE: ex_ready_o=1. Accept on ex_valid_i.
    - Non-LS (load=store=0): latch rd info and alu_res_i into wb registers. Next cycle wb_valid_o=1, fault_o=0. Stay in IDLE.
    - Legal LS: latch address, size, usign, direction, rd info; go to REQ.
    - Illegal LS: next cycle wb_valid_o=1, fault_o=1, wb_rd_wr_en_o=0, no memory request. Illegal means any of: load and store both set; zero or more than one size bit; misaligned address (half with a[0]; word with a[1:0]≠0; dw with a[2:0]≠0).
  - REQ: mem_req_valid_o=1 with all request fields held stable until mem_req_ready_i. On handshake go to RESP. ex_ready_o=0.
  - RESP: wait for mem_rsp_valid_i, then go to IDLE.
    - Load: wb_data_o = extracted lane, zero-extended if usign else sign-extended; wb_rd_wr_en_o = latched rd_wr_en.
    - Store: wb_rd_wr_en_o=0, wb_data_o=0.
    - wb_valid_o=1 in the cycle after the response.
- Latency:
  - Non-LS and faults: 1 cycle.
  - LS: 1 cycle of REQ (if ready is immediate) + response delay + 1 cycle.
  - Back-to-back accepts are allowed, since ex_ready_o returns to 1 in the same cycle as the wb pulse.
- Lane math, with a=addr[2:0]:
  - mem_req_addr_o = {addr[ADDR_W-1:3],3'b0}.
  - wdata = rs2_store_i << (8*a).
  - wstrb: byte 8'h01<<a; half 8'h03<<a; word 8'h0F<<a; dw 8'hFF.
  - rdata lane = mem_rsp_rdata_i >> (8*a), then truncated to size and extended.
- A response in REQ or IDLE is a protocol violation; it is ignored and does not change state.

Decomposition:
- Shared package holds:
  - LS_INFO bit-index constants: LOAD=0, STORE=1, USIGN=2, BYTE=3, DB=4, WORD=5, DW=6.
  - FSM state encoding (IDLE/REQ/RESP).
  - Size encoding.
- One combinational sub-module, ysyx_22040237_lsu_lane: inputs are a, size, usign, rs2, rdata; outputs are wdata, wstrb, extended load data, and a misalign flag.

Test Plan:
- Non-LS pass-through:
  - Stimulus: alu_res_i=64'h1234, rd=5, wen=1.
  - Response: next cycle wb_valid_o=1, wb_data_o=64'h1234, wb_rd_idx_o=5, no mem_req_valid_o.
- Signed byte load:
  - Stimulus: addr=0x8000_0003; rsp rdata=64'h0000_0000_8000_0000 with byte 3 = 0x80.
  - Response: req addr=0x8000_0000, wstrb=0; wb_data_o=64'hFFFF_FFFF_FFFF_FF80. With usign=1 the response is 64'h80.
- Halfword store with ready held low 3 cycles:
  - Stimulus: addr=...6, rs2=64'hABCD.
  - Response: mem_req_valid_o and fields stable 4 cycles; wstrb=8'hC0, wdata=64'hABCD_0000_0000_0000; wb_valid_o with wb_rd_wr_en_o=0.
- Misaligned word load:
  - Stimulus: addr=...2.
  - Response: no request; next cycle wb_valid_o=1, fault_o=1, wb_rd_wr_en_o=0.
- Reset mid-op:
  - Stimulus: assert rst while in RESP, then mem_rsp_valid_i=1 the cycle after reset.
  - Response: outputs 0, ex_ready_o=1, no wb_valid_o.
- Signed word load:
  - Stimulus: dw-aligned addr+4; rdata=64'h8765_4321_0000_0000.
  - Response: wb_data_o=64'hFFFF_FFFF_8765_4321.
- Back-to-back:
  - Stimulus: dw load followed immediately by a non-LS instruction.
  - Response: two wb_valid_o pulses, no lost instruction.
